// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between fetch and data ports with req/res handshakes.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin conflict resolution; default is fixed data priority.
module mem_port_arbiter #(
  parameter int AW = 8,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_res,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [3:0]    d_wen,
  input  logic [31:0]   d_wdata,
  output logic          d_res,
  output logic [31:0]   d_rdata,
  output logic          ram_en,
  output logic [3:0]    ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t     state;
  logic       sel_d;
  logic [1:0] cnt;
  logic       pick_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  // sel_d holds the last grant, so a conflict goes to the other port
  assign pick_d = d_req & (~if_req | ~sel_d);
`else
  assign pick_d = d_req;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      sel_d     <= 1'b0;
      cnt       <= '0;
      if_res    <= 1'b0;
      if_rdata  <= '0;
      d_res     <= 1'b0;
      d_rdata   <= '0;
      ram_en    <= 1'b0;
      ram_wen   <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (if_req || d_req) begin
          state     <= ISSUE;
          busy      <= 1'b1;
          sel_d     <= pick_d;
          ram_en    <= 1'b1;
          ram_addr  <= pick_d ? d_addr : if_addr;
          ram_wen   <= pick_d ? d_wen : 4'b0000;
          ram_wdata <= pick_d ? d_wdata : ram_wdata;
        end
        ISSUE: begin
          ram_en  <= 1'b0;
          ram_wen <= '0;
          cnt     <= '0;
          if (|ram_wen) begin
            state <= RESP;
            d_res <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (cnt == 2'(RAM_LAT - 1)) begin
          state  <= RESP;
          if_res <= ~sel_d;
          d_res  <= sel_d;
          if (sel_d) d_rdata <= ram_rdata;
          else if_rdata <= ram_rdata;
        end else begin
          cnt <= cnt + 2'd1;
        end
        RESP: begin
          state  <= IDLE;
          busy   <= 1'b0;
          if_res <= 1'b0;
          d_res  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
